// File: rtl/acia_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acia_pkg
//  Description : Shared definitions for the 6850-style ACIA serial front ends:
//                receiver state encoding and the default bit-period divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package acia_pkg;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Default bit period: 25 MHz system clock, 115200 baud
    localparam int c_clk_hz          = 25_000_000;
    localparam int c_baud            = 115_200;
    localparam int c_clk_div_default = c_clk_hz / c_baud;

endpackage
`default_nettype wire

// File: rtl/acia_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : acia_rx_fifo_if
//  Description : Show-ahead byte interface between the ACIA receive front end
//                and the register block (data/valid/pop plus sticky errors).
//  Revision    : 1.0 - initial release
// ============================================================================
interface acia_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  rx_re;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_full;
    logic [DEPTH_LOG2:0]   rx_count;
    logic                  ovr_err;
    logic                  frm_err;

    // Consumer side (ACIA register block)
    modport master (
        output rx_re,
        input  rx_data, rx_valid, rx_full, rx_count, ovr_err, frm_err
    );

    // Producer side (receive front end)
    modport slave (
        input  rx_re,
        output rx_data, rx_valid, rx_full, rx_count, ovr_err, frm_err
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock circular-buffer FIFO with show-ahead output,
//                exact occupancy count and push-while-full-with-pop support.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    i_push,
    input  wire                    i_pop,
    input  wire  [WIDTH-1:0]       i_din,
    output logic [WIDTH-1:0]       o_dout,
    output logic [DEPTH_LOG2:0]    o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int                  c_depth     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_depth_cnt = (DEPTH_LOG2 + 1)'(c_depth);

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    // A pop on an empty FIFO is ignored; a push when full only lands if a pop frees a slot
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_depth_cnt);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; memory is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/acia_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : acia_rx_fifo
//  Description : ACIA serial receive front end: rx synchroniser, 8N1 frame
//                deserialiser, byte FIFO and sticky overrun/framing flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module acia_rx_fifo
    import acia_pkg::*;
#(
    parameter int CLK_DIV    = c_clk_div_default,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire           clk,
    input  wire           reset,
    input  wire           rx,
    acia_rx_fifo_if.slave bus
);
    localparam int              c_tw        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Timer expires when it reaches zero, so a load of N-1 gives an N-cycle interval
    localparam logic [c_tw-1:0] c_half_load = c_tw'(CLK_DIV / 2 - 1);
    localparam logic [c_tw-1:0] c_full_load = c_tw'(CLK_DIV - 1);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    logic [c_tw-1:0] r_timer;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_push;
    logic [7:0]      r_push_byte;
    logic            r_frm_err;
    logic            r_ovr_err;

    logic                w_expired;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [7:0]          w_head;
    logic [DEPTH_LOG2:0] w_count;

    assign w_expired = (r_timer == '0);
    // Full and not drained this cycle: the arriving byte is lost
    assign w_drop    = r_push & w_full & ~bus.rx_re;

    // Two-flop synchroniser, preset to the idle (mark) level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Frame receiver: mid-bit sampling, LSB-first shift, stop check and framing flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_frm_err   <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (bus.rx_re) begin
                r_frm_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= ST_START;
                        r_timer <= c_half_load;
                    end
                end
                ST_START: begin
                    if (w_expired) begin
                        r_timer <= c_full_load;
                        if (r_sync2) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_expired) begin
                        r_timer <= c_full_load;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_expired) begin
                        r_timer <= c_full_load;
                        if (r_sync2) begin
                            r_push      <= 1'b1;
                            r_push_byte <= r_shift;
                            r_state     <= ST_IDLE;
                        end else begin
                            // Set takes priority over a same-cycle read clear
                            r_frm_err <= 1'b1;
                            r_state   <= ST_BREAK;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                        r_timer <= c_full_load;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= c_full_load;
                end
            endcase
        end
    end

    // Sticky overrun flag: set on a dropped byte, cleared by any data read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr_err <= 1'b0;
        end else if (w_drop) begin
            r_ovr_err <= 1'b1;
        end else if (bus.rx_re) begin
            r_ovr_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_push),
        .i_pop   (bus.rx_re),
        .i_din   (r_push_byte),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.rx_data  = w_head;
    assign bus.rx_valid = ~w_empty;
    assign bus.rx_full  = w_full;
    assign bus.rx_count = w_count;
    assign bus.ovr_err  = r_ovr_err;
    assign bus.frm_err  = r_frm_err;
endmodule
`default_nettype wire

// File: tb/tb_acia_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acia_rx_fifo
//  Description : Self-checking bench for acia_rx_fifo: directed frame table,
//                hand-written corner sequences and randomized frames checked
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acia_rx_fifo;
    localparam int D      = 65;            // bit period used by the bench
    localparam int H      = D / 2;         // half-bit start delay
    localparam int DL     = 4;
    localparam int DEPTH  = 1 << DL;
    // Frame-relative cycle indices (k = clock edges since the start bit began)
    localparam int K_FRM  = H + 9 * D + 2; // stop-bit sample edge
    localparam int K_PUSH = H + 9 * D + 3; // FIFO write edge
    localparam int K_ABORT = 2 + H + 5 * D - 5; // FSM waiting on data bit 4

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus sticky flags
    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_frm;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_count;
        logic [7:0] exp_head;
        bit         exp_frm;
    } vec_t;

    vec_t vec[4];

    acia_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    acia_rx_fifo #(
        .CLK_DIV    (D),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " valid"}, {31'b0, bus.rx_valid}, (q.size() != 0) ? 1 : 0);
        chk({tag, " count"}, {27'b0, bus.rx_count}, q.size());
        chk({tag, " full"},  {31'b0, bus.rx_full},  (q.size() == DEPTH) ? 1 : 0);
        chk({tag, " ovr"},   {31'b0, bus.ovr_err},  {31'b0, m_ovr});
        chk({tag, " frm"},   {31'b0, bus.frm_err},  {31'b0, m_frm});
        if (q.size() != 0) chk({tag, " data"}, {24'b0, bus.rx_data}, {24'b0, q[0]});
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
    endtask

    // One clock edge of the reference: pop (if anything stored), then push, then flags
    task automatic model_edge(input bit re, input bit push, input logic [7:0] pb, input bit frm);
        bit was_full;
        bit did_pop;
        was_full = (q.size() == DEPTH);
        did_pop  = re && (q.size() != 0);
        if (did_pop) void'(q.pop_front());
        if (push && (!was_full || did_pop)) q.push_back(pb);
        if (push && was_full && !did_pop) m_ovr = 1'b1;
        else if (re)                      m_ovr = 1'b0;
        if (frm)     m_frm = 1'b1;
        else if (re) m_frm = 1'b0;
    endtask

    // Called at a negedge: sets rx_re for the next posedge, steps the model, waits a cycle
    task automatic cyc(input bit re, input bit push, input logic [7:0] pb, input bit frm);
        bus.rx_re = re;
        model_edge(re, push, pb, frm);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        bus.rx_re = 1'b0;
        rx        = 1'b1;
        model_reset();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic level(input int k, input logic [7:0] b, input bit stop_ok, input bit brk);
        int j;
        j = k / D;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (brk)    return 1'b0;
        if (j == 9) return stop_ok;
        return 1'b1;
    endfunction

    // Drives one 8N1 frame; optional pop at a given edge, latency check, mid-frame reset,
    // random pops (1 in pop_rate cycles), and a break that keeps the line low afterwards
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int pop_k,
                              input bit chk_lat, input int abort_k, input int pop_rate,
                              input bit brk);
        for (int k = 0; k <= 10 * D; k++) begin
            bit re;
            if (k == abort_k) begin
                reset     = 1'b1;
                bus.rx_re = 1'b0;
                model_reset();
                @(negedge clk);
                reset = 1'b0;
                rx    = 1'b1;
                return;
            end
            if (chk_lat && k == K_PUSH)     chk("latency valid still low", {31'b0, bus.rx_valid}, 0);
            if (chk_lat && k == K_PUSH + 1) chk("latency valid high",      {31'b0, bus.rx_valid}, 1);
            rx = level(k, b, stop_ok, brk);
            re = (k == pop_k) || (pop_rate > 0 && $urandom_range(pop_rate - 1) == 0);
            cyc(re, stop_ok && !brk && k == K_PUSH, b, (!stop_ok || brk) && k == K_FRM);
        end
    endtask

    task automatic idle(input int n, input int pop_rate);
        rx = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc(pop_rate > 0 && $urandom_range(pop_rate - 1) == 0, 1'b0, 8'h00, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] expv;
        vec[0] = '{data: 8'h41, stop_ok: 1'b1, exp_count: 1, exp_head: 8'h41, exp_frm: 1'b0};
        vec[1] = '{data: 8'h80, stop_ok: 1'b1, exp_count: 2, exp_head: 8'h41, exp_frm: 1'b0};
        vec[2] = '{data: 8'hFF, stop_ok: 1'b1, exp_count: 3, exp_head: 8'h41, exp_frm: 1'b0};
        vec[3] = '{data: 8'h00, stop_ok: 1'b0, exp_count: 3, exp_head: 8'h41, exp_frm: 1'b1};

        bus.rx_re = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Reset state
        chk("reset valid", {31'b0, bus.rx_valid}, 0);
        chk("reset full",  {31'b0, bus.rx_full},  0);
        chk("reset count", {27'b0, bus.rx_count}, 0);
        chk("reset ovr",   {31'b0, bus.ovr_err},  0);
        chk("reset frm",   {31'b0, bus.frm_err},  0);
        chk("reset data",  {24'b0, bus.rx_data},  8'h00);

        // Single frame with exact valid latency, then one pop
        send_frame(8'h41, 1'b1, -1, 1'b1, -1, 0, 1'b0);
        chk("single data",  {24'b0, bus.rx_data},  8'h41);
        chk("single count", {27'b0, bus.rx_count}, 1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        bus.rx_re = 1'b0;
        chk("single pop valid", {31'b0, bus.rx_valid}, 0);
        chk("single pop count", {27'b0, bus.rx_count}, 0);

        // Glitch shorter than half a bit: false start, nothing recorded
        rx = 1'b0;
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        idle(2 * D, 0);
        chk("glitch count", {27'b0, bus.rx_count}, 0);
        chk("glitch frm",   {31'b0, bus.frm_err},  0);
        chk("glitch ovr",   {31'b0, bus.ovr_err},  0);

        // Frame table, no reads in between
        for (int i = 0; i < 4; i++) begin
            send_frame(vec[i].data, vec[i].stop_ok, -1, 1'b0, -1, 0, 1'b0);
            idle(4, 0);
            chk($sformatf("vec%0d count", i), {27'b0, bus.rx_count}, vec[i].exp_count);
            chk($sformatf("vec%0d head", i),  {24'b0, bus.rx_data},  {24'b0, vec[i].exp_head});
            chk($sformatf("vec%0d frm", i),   {31'b0, bus.frm_err},  {31'b0, vec[i].exp_frm});
            chk_model($sformatf("vec%0d model", i));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            bus.rx_re = 1'b0;
            chk_model($sformatf("vec drain%0d", i));
        end

        // Held-low stop bit then long break: one framing error, no byte, recovery
        send_frame(8'h55, 1'b0, -1, 1'b0, -1, 0, 1'b1);
        chk("break frm",   {31'b0, bus.frm_err},  1);
        chk("break valid", {31'b0, bus.rx_valid}, 0);
        for (int i = 0; i < 5000; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        idle(4, 0);
        chk("break frm held",  {31'b0, bus.frm_err},  1);
        chk("break no byte",   {27'b0, bus.rx_count}, 0);
        send_frame(8'h0D, 1'b1, -1, 1'b0, -1, 0, 1'b0);
        idle(4, 0);
        chk("after break data", {24'b0, bus.rx_data}, 8'h0D);
        chk("after break frm",  {31'b0, bus.frm_err}, 1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        bus.rx_re = 1'b0;
        chk("frm cleared", {31'b0, bus.frm_err},  0);
        chk("frm cleared valid", {31'b0, bus.rx_valid}, 0);

        // 17 back-to-back frames into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1, -1, 1'b0, -1, 0, 1'b0);
        end
        chk("ovr full",  {31'b0, bus.rx_full},  1);
        chk("ovr count", {27'b0, bus.rx_count}, 16);
        chk("ovr flag",  {31'b0, bus.ovr_err},  1);
        chk_model("ovr model");

        // Full FIFO, pop coincides with the next push: no overrun, byte lands at tail
        send_frame(8'h77, 1'b1, K_PUSH, 1'b0, -1, 0, 1'b0);
        chk("fullpop count", {27'b0, bus.rx_count}, 16);
        chk("fullpop ovr",   {31'b0, bus.ovr_err},  0);
        chk_model("fullpop model");
        for (int i = 0; i < 16; i++) begin
            expv = (i < 15) ? 8'(i + 1) : 8'h77;
            chk($sformatf("drain%0d", i), {24'b0, bus.rx_data}, {24'b0, expv});
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
        end
        bus.rx_re = 1'b0;
        chk("drain empty", {31'b0, bus.rx_valid}, 0);

        // Reset during data bit 4 with bytes queued
        send_frame(8'h11, 1'b1, -1, 1'b0, -1, 0, 1'b0);
        send_frame(8'h22, 1'b1, -1, 1'b0, -1, 0, 1'b0);
        send_frame(8'h33, 1'b1, -1, 1'b0, -1, 0, 1'b0);
        chk("pre-reset count", {27'b0, bus.rx_count}, 3);
        send_frame(8'hA5, 1'b1, -1, 1'b0, K_ABORT, 0, 1'b0);
        chk("midreset count", {27'b0, bus.rx_count}, 0);
        chk("midreset valid", {31'b0, bus.rx_valid}, 0);
        chk("midreset ovr",   {31'b0, bus.ovr_err},  0);
        chk("midreset frm",   {31'b0, bus.frm_err},  0);
        chk("midreset data",  {24'b0, bus.rx_data},  8'h00);
        idle(12 * D, 0);
        chk("midreset no push", {27'b0, bus.rx_count}, 0);
        send_frame(8'h3C, 1'b1, -1, 1'b0, -1, 0, 1'b0);
        idle(4, 0);
        chk("post-reset data",  {24'b0, bus.rx_data},  8'h3C);
        chk("post-reset count", {27'b0, bus.rx_count}, 1);
        chk_model("post-reset model");

        // Randomized frames, errors and pops against the reference model
        for (int i = 0; i < 30; i++) begin
            int rate;
            rate = (i < 20) ? 0 : 60;
            send_frame(8'($urandom), $urandom_range(9) != 0, -1, 1'b0, -1, rate, 1'b0);
            idle($urandom_range(20, 2), rate);
            bus.rx_re = 1'b0;
            chk_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
